// File: rtl/sub16_nibble_serial_if.sv
// rtl/sub16_nibble_serial_if.sv - operand/result handshake bundle for the nibble-serial subtractor
interface sub16_nibble_serial_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf, zero
   );
endinterface

// File: rtl/sub16_nibble_serial.sv
// rtl/sub16_nibble_serial.sv - sequential a - b - bin, one NIBBLE slice per clock, valid/ready at both ends
module sub16_nibble_serial #(
   parameter int WIDTH  = 16,
   parameter int NIBBLE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sub16_nibble_serial_if.slave  bus
);
   localparam int N  = WIDTH / NIBBLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    k;
   logic [WIDTH-1:0] a_w;
   logic [WIDTH-1:0] b_w;
   logic [WIDTH-1:0] d_w;
   logic             borrow;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;
   logic             ovf_r;
   logic             zero_r;
   logic             in_ready_r;
   logic             out_valid_r;

   logic [NIBBLE:0]  nib_sub;
   logic [WIDTH-1:0] d_next;

   // The top bit of the widened slice subtract is the borrow into the next nibble.
   always_comb begin
      nib_sub = {1'b0, a_w[k*NIBBLE +: NIBBLE]}
              - {1'b0, b_w[k*NIBBLE +: NIBBLE]}
              - {{NIBBLE{1'b0}}, borrow};
      d_next = d_w;
      d_next[k*NIBBLE +: NIBBLE] = nib_sub[NIBBLE-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         k           <= '0;
         a_w         <= '0;
         b_w         <= '0;
         d_w         <= '0;
         borrow      <= 1'b0;
         diff_r      <= '0;
         bout_r      <= 1'b0;
         ovf_r       <= 1'b0;
         zero_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_w        <= bus.a;
                  b_w        <= bus.b;
                  borrow     <= bus.bin;
                  d_w        <= '0;
                  k          <= '0;
                  in_ready_r <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               d_w    <= d_next;
               borrow <= nib_sub[NIBBLE];
               k      <= k + 1'b1;
               // Results are published only here, so diff never shows a partial value.
               if (k == CW'(N - 1)) begin
                  diff_r      <= d_next;
                  bout_r      <= nib_sub[NIBBLE];
                  ovf_r       <= (a_w[WIDTH-1] != b_w[WIDTH-1]) &&
                                 (d_next[WIDTH-1] != a_w[WIDTH-1]);
                  zero_r      <= (d_next == '0);
                  k           <= '0;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.diff      = diff_r;
   assign bus.bout      = bout_r;
   assign bus.ovf       = ovf_r;
   assign bus.zero      = zero_r;
endmodule

// File: tb/tb_sub16_nibble_serial.sv
// tb/tb_sub16_nibble_serial.sv - directed and random scoreboard bench for sub16_nibble_serial
module tb_sub16_nibble_serial;
   typedef struct packed {
      logic [15:0] diff;
      logic        bout;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   sub16_nibble_serial_if #(.WIDTH(16)) bus ();

   sub16_nibble_serial #(.WIDTH(16), .NIBBLE(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic ov, input logic z);
      exp_t e;
      e.diff = d; e.bout = bo; e.ovf = ov; e.zero = z;
      return e;
   endfunction

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
      logic [16:0] t;
      t = {1'b0, a} - {1'b0, b} - {16'b0, bi};
      return mk(t[15:0], t[16], (a[15] != b[15]) && (t[15] != a[15]), t[15:0] == 16'h0);
   endfunction

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         input exp_t e, input int hold);
      int   w;
      int   lat;
      bit   ir_bad;
      bit   hold_bad;
      exp_t p;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      check("accept_ready", bus.in_ready, 1);
      bus.a = a; bus.b = b; bus.bin = bi; bus.in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'($urandom);
      lat = 0; ir_bad = 0;
      while (!bus.out_valid && lat < 20) begin
         if (bus.in_ready) ir_bad = 1;
         @(posedge clk); #1; lat++;
      end
      check("latency", lat, 4);
      check("in_ready_busy", ir_bad, 0);
      check("in_ready_done", bus.in_ready, 0);
      p = sb.pop_front();
      check("diff", bus.diff, p.diff);
      check("bout", bus.bout, p.bout);
      check("ovf", bus.ovf, p.ovf);
      check("zero", bus.zero, p.zero);
      hold_bad = 0;
      repeat (hold) begin
         @(posedge clk); #1;
         bus.in_valid = ~bus.in_valid;
         bus.a = 16'($urandom); bus.b = 16'($urandom);
         if (!bus.out_valid || bus.in_ready || bus.diff !== p.diff || bus.bout !== p.bout ||
             bus.ovf !== p.ovf || bus.zero !== p.zero) hold_bad = 1;
      end
      if (hold > 0) check("hold_stable", hold_bad, 0);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("release_out_valid", bus.out_valid, 0);
      check("release_in_ready", bus.in_ready, 1);
      check("idle_hold_diff", bus.diff, p.diff);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rbi;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_diff", bus.diff, 0);
      check("rst_flags", {bus.bout, bus.ovf, bus.zero}, 0);
      rst_n = 1'b1;

      run_op(16'h0005, 16'h0003, 1'b0, mk(16'h0002, 0, 0, 0), 0);
      run_op(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1, 0, 0), 0);
      run_op(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 0, 1, 0), 0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1, 1, 0), 0);
      run_op(16'h1234, 16'h1233, 1'b1, mk(16'h0000, 0, 0, 1), 0);
      run_op(16'hFFF8, 16'hFFFF, 1'b0, mk(16'hFFF9, 1, 0, 0), 0);
      run_op(16'h00FF, 16'h000F, 1'b0, mk(16'h00F0, 0, 0, 0), 10);
      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom);
         run_op(ra, rb, rbi, model(ra, rb, rbi), i);
      end
      run_op(16'h00FF, 16'h000F, 1'b0, mk(16'h00F0, 0, 0, 0), 0);

      // Abort after two RUN edges; outputs must clear without waiting for a clock.
      bus.a = 16'hABCD; bus.b = 16'h1111; bus.bin = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_diff", bus.diff, 0);
      check("abort_flags", {bus.bout, bus.ovf, bus.zero}, 0);
      check("abort_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check("rst_no_capture", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_no_result", bus.out_valid, 0);
      rst_n = 1'b1;
      run_op(16'hABCD, 16'h1111, 1'b0, mk(16'h9ABC, 0, 0, 0), 0);

      check("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
